// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with a one-entry skid
//               buffer, branch redirect squash and halt detection.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [15:0] branch_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic        instr_valid,
    output logic        halted
);

    localparam logic [1:0] c_st_fetch  = 2'd0;
    localparam logic [1:0] c_st_squash = 2'd1;
    localparam logic [1:0] c_st_full   = 2'd2;
    localparam logic [1:0] c_st_halt   = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic [15:0] pc_q,       pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] skid_q,     skid_d;
    logic [15:0] skid_pc_q,  skid_pc_d;
    logic [15:0] instr_q,    instr_d;
    logic [15:0] pc_out_q,   pc_out_d;
    logic        valid_q,    valid_d;

    logic w_redirect;
    logic w_data_halt;
    logic w_skid_halt;

    assign w_redirect  = branch_taken & ~stall;
    assign w_data_halt = (imem_data[15:12] == HLT_OPCODE);
    assign w_skid_halt = (skid_q[15:12] == HLT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_st_fetch;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            skid_q     <= 16'h0000;
            skid_pc_q  <= 16'h0000;
            instr_q    <= 16'h0000;
            pc_out_q   <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;

        case (state_q)
            c_st_fetch: begin
                // Redirect wins over capture, so a halt word arriving with it is dropped
                if (w_redirect) begin
                    pc_d    = branch_pc;
                    valid_d = 1'b0;
                    state_d = imem_ready ? c_st_fetch : c_st_squash;
                end else if (imem_ready) begin
                    pc_d = req_addr_q + 16'd2;
                    if (stall) begin
                        skid_d    = imem_data;
                        skid_pc_d = req_addr_q;
                        state_d   = c_st_full;
                    end else begin
                        instr_d  = imem_data;
                        pc_out_d = req_addr_q;
                        valid_d  = 1'b1;
                        state_d  = w_data_halt ? c_st_halt : c_st_fetch;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            c_st_squash: begin
                valid_d = 1'b0;
                if (w_redirect) begin
                    pc_d = branch_pc;
                end
                if (imem_ready) begin
                    state_d = c_st_fetch;
                end
            end
            c_st_full: begin
                if (w_redirect) begin
                    pc_d    = branch_pc;
                    valid_d = 1'b0;
                    state_d = c_st_fetch;
                end else if (!stall) begin
                    instr_d  = skid_q;
                    pc_out_d = skid_pc_q;
                    valid_d  = 1'b1;
                    state_d  = w_skid_halt ? c_st_halt : c_st_fetch;
                end
            end
            default: begin
                if (!stall) begin
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    // A fresh request is launched at pc whenever the next state is FETCH
    always_comb begin
        req_addr_d = (state_d == c_st_fetch) ? pc_d : req_addr_q;
    end

    always_comb begin
        imem_req    = (state_q == c_st_fetch) || (state_q == c_st_squash);
        imem_addr   = req_addr_q;
        halted      = (state_q == c_st_halt);
        instr_out   = instr_q;
        pc_out      = pc_out_q;
        instr_valid = valid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a latency-programmable
//               instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [15:0] branch_pc;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic        instr_valid;
    logic        halted;

    fetch_unit #(
        .RESET_PC   (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] exp_addr_q [$];
    logic [31:0] exp_ins_q  [$];
    logic [15:0] mem_tbl [logic [15:0]];

    int          lat    = 1;
    int          budget = 0;
    logic        mem_active;
    int          mem_cnt;
    logic [15:0] mem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_tbl.exists(a)) return mem_tbl[a];
        return {4'h1, a[11:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ins(input logic [15:0] pc, input logic [15:0] ins);
        exp_ins_q.push_back({pc, ins});
    endtask

    // Memory: serves one request at a time after 'lat' cycles while budget lasts
    initial begin
        logic [15:0] e;
        imem_ready = 1'b0;
        imem_data  = 16'h0000;
        mem_active = 1'b0;
        mem_cnt    = 0;
        mem_addr   = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            imem_ready = 1'b0;
            if (rst !== 1'b0) begin
                mem_active = 1'b0;
            end else if (imem_req === 1'b1) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_cnt    = 0;
                    mem_addr   = imem_addr;
                    if (budget > 0) begin
                        if (exp_addr_q.size() == 0) begin
                            n_total++;
                            n_bad++;
                            $display("FAIL req_addr: actual=%h required=none", imem_addr);
                        end else begin
                            e = exp_addr_q.pop_front();
                            check("req_addr", imem_addr, e);
                        end
                    end
                end else begin
                    check("req_addr_stable", imem_addr, mem_addr);
                end
                mem_cnt++;
                if (mem_cnt >= lat && budget > 0) begin
                    imem_ready = 1'b1;
                    imem_data  = mem_rd(mem_addr);
                    budget--;
                    mem_active = 1'b0;
                end
            end else begin
                mem_active = 1'b0;
            end
        end
    end

    // Monitor: a handoff happens in any cycle decode sees a valid word without stalling
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && instr_valid === 1'b1 && stall === 1'b0) begin
                if (exp_ins_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL instr_handoff: actual=%h@%h required=none", instr_out, pc_out);
                end else begin
                    e = exp_ins_q.pop_front();
                    check("instr_pc", pc_out, e[31:16]);
                    check("instr_word", instr_out, e[15:0]);
                end
            end
        end
    end

    task automatic reset_begin();
        rst          = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_pc    = 16'h0000;
        budget       = 0;
        tick();
        tick();
        exp_addr_q.delete();
        exp_ins_q.delete();
        mem_tbl.delete();
        check("rst_valid", 16'(instr_valid), 16'h0000);
        check("rst_halted", 16'(halted), 16'h0000);
        check("rst_req", 16'(imem_req), 16'h0001);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_pc_out", pc_out, 16'h0000);
        check("rst_instr_out", instr_out, 16'h0000);
    endtask

    task automatic drain(input string name);
        check({name, "_addr_left"}, 16'(exp_addr_q.size()), 16'h0000);
        check({name, "_instr_left"}, 16'(exp_ins_q.size()), 16'h0000);
    endtask

    initial begin
        int found;

        // Straight-line fetch, 1-cycle memory
        reset_begin();
        mem_tbl[16'h0000] = 16'h1000;
        mem_tbl[16'h0002] = 16'h2000;
        mem_tbl[16'h0004] = 16'h3000;
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004};
        push_ins(16'h0000, 16'h1000);
        push_ins(16'h0002, 16'h2000);
        push_ins(16'h0004, 16'h3000);
        lat = 1; budget = 3; rst = 1'b0;
        repeat (6) tick();
        check("a_bubble", 16'(instr_valid), 16'h0000);
        check("a_next_addr", imem_addr, 16'h0006);
        drain("a");

        // Skid buffer under a 3-cycle stall
        reset_begin();
        mem_tbl[16'h0004] = 16'hA123;
        mem_tbl[16'h0006] = 16'h4000;
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        push_ins(16'h0000, 16'h1000);
        push_ins(16'h0002, 16'h1002);
        push_ins(16'h0004, 16'hA123);
        push_ins(16'h0006, 16'h4000);
        lat = 1; budget = 4; rst = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        tick();
        check("b_full_req", 16'(imem_req), 16'h0000);
        check("b_held_instr", instr_out, 16'h1002);
        check("b_held_pc", pc_out, 16'h0002);
        tick();
        check("b_full_req2", 16'(imem_req), 16'h0000);
        tick();
        stall = 1'b0;
        tick();
        check("b_skid_instr", instr_out, 16'hA123);
        check("b_skid_pc", pc_out, 16'h0004);
        check("b_next_addr", imem_addr, 16'h0006);
        repeat (3) tick();
        drain("b");

        // Redirect while a 4-cycle request is pending
        reset_begin();
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0040};
        push_ins(16'h0000, 16'h1000);
        push_ins(16'h0002, 16'h1002);
        push_ins(16'h0004, 16'h1004);
        push_ins(16'h0006, 16'h1006);
        push_ins(16'h0040, 16'h1040);
        lat = 4; budget = 6; rst = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (imem_req === 1'b1 && imem_addr === 16'h0008) found = 1;
        end
        if (found == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL c_wait_0008: actual=timeout required=request");
        end
        tick();
        branch_taken = 1'b1;
        branch_pc    = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("c_squash_valid", 16'(instr_valid), 16'h0000);
        check("c_squash_addr", imem_addr, 16'h0008);
        tick();
        tick();
        check("c_redir_addr", imem_addr, 16'h0040);
        check("c_redir_valid", 16'(instr_valid), 16'h0000);
        repeat (8) tick();
        drain("c");

        // Halt word stops fetch
        reset_begin();
        mem_tbl[16'h000C] = 16'hF000;
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h000C};
        for (int i = 0; i < 6; i++) push_ins(16'(2 * i), 16'(16'h1000 + 2 * i));
        push_ins(16'h000C, 16'hF000);
        lat = 1; budget = 7; rst = 1'b0;
        repeat (10) tick();
        check("d_halted", 16'(halted), 16'h0001);
        check("d_req_off", 16'(imem_req), 16'h0000);
        check("d_valid_clr", 16'(instr_valid), 16'h0000);
        check("d_halt_pc", pc_out, 16'h000C);
        repeat (5) tick();
        check("d_halted_late", 16'(halted), 16'h0001);
        check("d_req_off_late", 16'(imem_req), 16'h0000);
        drain("d");

        // Halt word arriving with a redirect does not halt
        reset_begin();
        mem_tbl[16'h000C] = 16'hF000;
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h000C, 16'h0100};
        for (int i = 0; i < 6; i++) push_ins(16'(2 * i), 16'(16'h1000 + 2 * i));
        push_ins(16'h0100, 16'h1100);
        lat = 1; budget = 8; rst = 1'b0;
        repeat (6) tick();
        branch_taken = 1'b1;
        branch_pc    = 16'h0100;
        tick();
        branch_taken = 1'b0;
        check("e_not_halted", 16'(halted), 16'h0000);
        check("e_valid", 16'(instr_valid), 16'h0000);
        check("e_redir_addr", imem_addr, 16'h0100);
        repeat (3) tick();
        check("e_not_halted_late", 16'(halted), 16'h0000);
        drain("e");

        // PC wraps from 0xFFFE to 0x0000
        reset_begin();
        exp_addr_q = '{16'h0000, 16'h0002, 16'hFFFE, 16'h0000};
        push_ins(16'h0000, 16'h1000);
        push_ins(16'hFFFE, 16'h1FFE);
        push_ins(16'h0000, 16'h1000);
        lat = 1; budget = 4; rst = 1'b0;
        tick();
        branch_taken = 1'b1;
        branch_pc    = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        check("f_valid", 16'(instr_valid), 16'h0000);
        check("f_addr_fffe", imem_addr, 16'hFFFE);
        tick();
        check("f_wrap_addr", imem_addr, 16'h0000);
        check("f_pc_fffe", pc_out, 16'hFFFE);
        check("f_instr_fffe", instr_out, 16'h1FFE);
        repeat (4) tick();
        drain("f");

        // Reset in the middle of a squash
        reset_begin();
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0000};
        push_ins(16'h0000, 16'h1000);
        push_ins(16'h0000, 16'h1000);
        lat = 4; budget = 2; rst = 1'b0;
        repeat (5) tick();
        branch_taken = 1'b1;
        branch_pc    = 16'h0080;
        tick();
        branch_taken = 1'b0;
        check("g_squash_addr", imem_addr, 16'h0002);
        check("g_squash_valid", 16'(instr_valid), 16'h0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("g_rst_addr", imem_addr, 16'h0000);
        check("g_rst_valid", 16'(instr_valid), 16'h0000);
        check("g_rst_req", 16'(imem_req), 16'h0001);
        repeat (7) tick();
        drain("g");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
